// File: rtl/pipe_hazard_ctrl.sv
// Hazard/control unit for the five-stage Y86-64 pipeline: stall/bubble generation,
// RUN/DRAIN/HALTED sequencing, and optional performance counters (PIPE_PERF_CNT_EN).
module pipe_hazard_ctrl #(
  parameter int                ICODE_W = 4,
  parameter int                REG_W   = 4,
  parameter logic [REG_W-1:0]  RNONE   = {REG_W{1'b1}},
  parameter int                STAT_W  = 3,
  parameter int                CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ICODE_W-1:0] D_icode,
  input  logic [REG_W-1:0]   d_srcA,
  input  logic [REG_W-1:0]   d_srcB,
  input  logic [ICODE_W-1:0] E_icode,
  input  logic [REG_W-1:0]   E_dstM,
  input  logic               e_cnd,
  input  logic [ICODE_W-1:0] M_icode,
  input  logic [STAT_W-1:0]  m_stat,
  input  logic [ICODE_W-1:0] W_icode,
  input  logic [STAT_W-1:0]  W_stat,
  output logic               F_stall,
  output logic               D_stall,
  output logic               D_bubble,
  output logic               E_bubble,
  output logic               M_bubble,
  output logic               W_stall,
  output logic               set_cc_en,
  output logic [1:0]         state,
  output logic [STAT_W-1:0]  halt_stat,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   mispred_cnt
);

  localparam logic [ICODE_W-1:0] I_NOP    = ICODE_W'(4'h1);
  localparam logic [ICODE_W-1:0] I_MRMOVQ = ICODE_W'(4'h5);
  localparam logic [ICODE_W-1:0] I_OPQ    = ICODE_W'(4'h6);
  localparam logic [ICODE_W-1:0] I_JXX    = ICODE_W'(4'h7);
  localparam logic [ICODE_W-1:0] I_RET    = ICODE_W'(4'h9);
  localparam logic [ICODE_W-1:0] I_POPQ   = ICODE_W'(4'hB);
  localparam logic [STAT_W-1:0]  S_AOK    = STAT_W'(1);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [STAT_W-1:0] halt_q, halt_d;
  logic              loaduse, mispred, retq, mexc, wexc;

  assign loaduse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign mispred = (E_icode == I_JXX) && !e_cnd;
  assign retq    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mexc    = (m_stat != S_AOK);
  assign wexc    = (W_stat != S_AOK);

  always_comb begin
    F_stall   = 1'b0;
    D_stall   = 1'b0;
    D_bubble  = 1'b0;
    E_bubble  = 1'b0;
    M_bubble  = 1'b0;
    W_stall   = 1'b0;
    set_cc_en = 1'b0;
    case (state_q)
      S_RUN, S_DRAIN: begin
        F_stall   = loaduse | retq;
        D_stall   = loaduse;
        // a load/use stall holds D, so the ret bubble must wait
        D_bubble  = mispred | (retq & ~loaduse);
        E_bubble  = mispred | loaduse;
        M_bubble  = mexc | wexc | (state_q == S_DRAIN);
        W_stall   = wexc;
        set_cc_en = (state_q == S_RUN) && (E_icode == I_OPQ) && !mexc && !wexc;
      end
      default: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    case (state_q)
      S_RUN: begin
        if (wexc) begin
          state_d = S_HALTED;
          halt_d  = W_stat;
        end else if (mexc) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (wexc) begin
          state_d = S_HALTED;
          halt_d  = W_stat;
        end
      end
      // the unused encoding collapses into HALTED
      default: state_d = S_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      halt_q  <= S_AOK;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  assign state     = state_q;
  assign halt_stat = halt_q;

`ifdef PIPE_PERF_CNT_EN
  logic [3:0]            cnt_inc;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_inc[0] = (state_q != S_HALTED);
  assign cnt_inc[1] = (W_icode != I_NOP) && (W_stat == S_AOK) && (state_q != S_HALTED);
  assign cnt_inc[2] = F_stall && (state_q == S_RUN);
  assign cnt_inc[3] = mispred && ((state_q == S_RUN) || (state_q == S_DRAIN));

  always_comb begin
    for (int i = 0; i < 4; i++)
      cnt_d[i] = (cnt_inc[i] && (cnt_q[i] != {CNT_W{1'b1}})) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cycle_cnt   = cnt_q[0];
  assign retire_cnt  = cnt_q[1];
  assign stall_cnt   = cnt_q[2];
  assign mispred_cnt = cnt_q[3];
`else
  logic unused_w_icode;
  assign unused_w_icode = ^W_icode;
  assign cycle_cnt      = '0;
  assign retire_cnt     = '0;
  assign stall_cnt      = '0;
  assign mispred_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; counters use a narrow width so saturation is reachable.
module tb_pipe_hazard_ctrl;
  localparam int CW = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1;
  logic [3:0]    D_icode, E_icode, M_icode, W_icode, d_srcA, d_srcB, E_dstM;
  logic          e_cnd;
  logic [2:0]    m_stat, W_stat;
  logic          F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en;
  logic [1:0]    state;
  logic [2:0]    halt_stat;
  logic [CW-1:0] cycle_cnt, retire_cnt, stall_cnt, mispred_cnt;
  logic [6:0]    ctrl;
  int            errors = 0, checks = 0;

  assign ctrl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en};

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd), .M_icode(M_icode), .m_stat(m_stat),
    .W_icode(W_icode), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .set_cc_en(set_cc_en), .state(state), .halt_stat(halt_stat), .cycle_cnt(cycle_cnt),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt), .mispred_cnt(mispred_cnt));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
    d_srcA = 4'h0; d_srcB = 4'h0; E_dstM = 4'hF; e_cnd = 1'b1;
    m_stat = 3'd1; W_stat = 3'd1;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  function automatic logic [CW-1:0] ec(input int n);
    return PERF ? CW'(n) : '0;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (halt_stat !== 3'd1) begin errors++; $display("FAIL rst_halt got=%0d exp=1", halt_stat); end
    checks++; if (ctrl !== 7'b0) begin errors++; $display("FAIL rst_ctrl got=%b exp=%b", ctrl, 7'b0); end
    checks++; if (cycle_cnt !== ec(0)) begin errors++; $display("FAIL rst_cyc got=%0d exp=%0d", cycle_cnt, ec(0)); end
    tick();
    checks++; if (cycle_cnt !== ec(1)) begin errors++; $display("FAIL cyc1 got=%0d exp=%0d", cycle_cnt, ec(1)); end
    tick();
    checks++; if (cycle_cnt !== ec(2)) begin errors++; $display("FAIL cyc2 got=%0d exp=%0d", cycle_cnt, ec(2)); end
    checks++; if (retire_cnt !== ec(0)) begin errors++; $display("FAIL rst_ret got=%0d exp=%0d", retire_cnt, ec(0)); end
  endtask

  task automatic test_loaduse();
    do_reset();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
    checks++; if (ctrl !== 7'b1101000) begin errors++; $display("FAIL lu_mrmov got=%b exp=%b", ctrl, 7'b1101000); end
    tick();
    checks++; if (stall_cnt !== ec(1)) begin errors++; $display("FAIL lu_stallcnt got=%0d exp=%0d", stall_cnt, ec(1)); end
    E_dstM = 4'hF; d_srcA = 4'hF; #1;
    checks++; if (ctrl !== 7'b0) begin errors++; $display("FAIL lu_rnone got=%b exp=%b", ctrl, 7'b0); end
    E_icode = 4'hB; E_dstM = 4'h4; d_srcA = 4'h0; d_srcB = 4'h4; #1;
    checks++; if (ctrl !== 7'b1101000) begin errors++; $display("FAIL lu_popq got=%b exp=%b", ctrl, 7'b1101000); end
    E_icode = 4'h6; #1;
    checks++; if (ctrl !== 7'b0000001) begin errors++; $display("FAIL opq_cc got=%b exp=%b", ctrl, 7'b0000001); end
    tick();
    checks++; if (stall_cnt !== ec(1)) begin errors++; $display("FAIL lu_stallcnt2 got=%0d exp=%0d", stall_cnt, ec(1)); end
  endtask

  task automatic test_mispred();
    do_reset();
    E_icode = 4'h7; e_cnd = 1'b0; #1;
    checks++; if (ctrl !== 7'b0011000) begin errors++; $display("FAIL mp_taken got=%b exp=%b", ctrl, 7'b0011000); end
    tick();
    checks++; if (mispred_cnt !== ec(1)) begin errors++; $display("FAIL mp_cnt got=%0d exp=%0d", mispred_cnt, ec(1)); end
    e_cnd = 1'b1; #1;
    checks++; if (ctrl !== 7'b0) begin errors++; $display("FAIL mp_ok got=%b exp=%b", ctrl, 7'b0); end
    tick();
    checks++; if (mispred_cnt !== ec(1)) begin errors++; $display("FAIL mp_cnt2 got=%0d exp=%0d", mispred_cnt, ec(1)); end
  endtask

  task automatic test_ret();
    do_reset();
    D_icode = 4'h9; #1;
    checks++; if (ctrl !== 7'b1010000) begin errors++; $display("FAIL ret_D got=%b exp=%b", ctrl, 7'b1010000); end
    tick(); D_icode = 4'h1; E_icode = 4'h9; #1;
    checks++; if (ctrl !== 7'b1010000) begin errors++; $display("FAIL ret_E got=%b exp=%b", ctrl, 7'b1010000); end
    tick(); E_icode = 4'h1; M_icode = 4'h9; #1;
    checks++; if (ctrl !== 7'b1010000) begin errors++; $display("FAIL ret_M got=%b exp=%b", ctrl, 7'b1010000); end
    tick(); M_icode = 4'h1;
    checks++; if (stall_cnt !== ec(3)) begin errors++; $display("FAIL ret_stallcnt got=%0d exp=%0d", stall_cnt, ec(3)); end
    D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
    checks++; if (ctrl !== 7'b1101000) begin errors++; $display("FAIL ret_lu got=%b exp=%b", ctrl, 7'b1101000); end
    E_icode = 4'h7; e_cnd = 1'b0; #1;
    checks++; if (ctrl !== 7'b1011000) begin errors++; $display("FAIL ret_mp got=%b exp=%b", ctrl, 7'b1011000); end
    idle(); #1;
  endtask

  task automatic test_drain_halt();
    do_reset();
    E_icode = 4'h6; m_stat = 3'd3; #1;
    checks++; if (ctrl !== 7'b0000100) begin errors++; $display("FAIL mexc_ctrl got=%b exp=%b", ctrl, 7'b0000100); end
    tick(); m_stat = 3'd1; #1;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL drain_state got=%0d exp=1", state); end
    checks++; if (ctrl !== 7'b0000100) begin errors++; $display("FAIL drain_ctrl got=%b exp=%b", ctrl, 7'b0000100); end
    W_stat = 3'd3; #1;
    checks++; if (ctrl !== 7'b0000110) begin errors++; $display("FAIL drain_wexc got=%b exp=%b", ctrl, 7'b0000110); end
    tick(); W_stat = 3'd1; E_icode = 4'h7; e_cnd = 1'b0; #1;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL halt_state got=%0d exp=2", state); end
    checks++; if (halt_stat !== 3'd3) begin errors++; $display("FAIL halt_stat got=%0d exp=3", halt_stat); end
    checks++; if (ctrl !== 7'b1100110) begin errors++; $display("FAIL halt_ctrl got=%b exp=%b", ctrl, 7'b1100110); end
    checks++; if (cycle_cnt !== ec(2)) begin errors++; $display("FAIL halt_cyc got=%0d exp=%0d", cycle_cnt, ec(2)); end
    tick(); tick();
    checks++; if (cycle_cnt !== ec(2)) begin errors++; $display("FAIL frozen_cyc got=%0d exp=%0d", cycle_cnt, ec(2)); end
    checks++; if (mispred_cnt !== ec(0)) begin errors++; $display("FAIL halt_mp got=%0d exp=%0d", mispred_cnt, ec(0)); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL halt_hold got=%0d exp=2", state); end
    idle(); rst = 1'b1; tick(); rst = 1'b0; #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL unhalt_state got=%0d exp=0", state); end
    checks++; if (halt_stat !== 3'd1) begin errors++; $display("FAIL unhalt_stat got=%0d exp=1", halt_stat); end
    checks++; if (cycle_cnt !== ec(0)) begin errors++; $display("FAIL unhalt_cyc got=%0d exp=%0d", cycle_cnt, ec(0)); end
  endtask

  task automatic test_priority_reset();
    do_reset();
    m_stat = 3'd3; W_stat = 3'd4; tick(); idle(); #1;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL prio_state got=%0d exp=2", state); end
    checks++; if (halt_stat !== 3'd4) begin errors++; $display("FAIL prio_stat got=%0d exp=4", halt_stat); end
    do_reset();
    m_stat = 3'd2; tick(); m_stat = 3'd1; W_stat = 3'd2; rst = 1'b1; tick(); rst = 1'b0; idle(); #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL drainrst_state got=%0d exp=0", state); end
    checks++; if (halt_stat !== 3'd1) begin errors++; $display("FAIL drainrst_stat got=%0d exp=1", halt_stat); end
  endtask

  task automatic test_counters();
    do_reset();
    W_icode = 4'h6; tick(); tick(); W_icode = 4'h1; tick();
    checks++; if (retire_cnt !== ec(2)) begin errors++; $display("FAIL retire got=%0d exp=%0d", retire_cnt, ec(2)); end
    repeat (20) tick();
    checks++; if (cycle_cnt !== ec(15)) begin errors++; $display("FAIL cyc_sat got=%0d exp=%0d", cycle_cnt, ec(15)); end
  endtask

  initial begin
    idle();
    test_reset();
    test_loaduse();
    test_mispred();
    test_ret();
    test_drain_halt();
    test_priority_reset();
    test_counters();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and control unit for the five-stage Y86-64 pipeline (fetch, decode, execute, memory, writeback).
- Generates per-stage stall/bubble controls for load/use, branch mispredict and ret hazards.
- Gates condition-code updates on exceptions.
- Runs a RUN/DRAIN/HALTED state machine so the pipeline stops cleanly on a non-AOK status.
- Optionally keeps saturating performance counters.
- Sits beside the stage registers; every stage register's stall/bubble inputs come from this block.

Parameters:
ICODE_W, 4, instruction-code width
REG_W, 4, register-ID width
RNONE, 4'hF, "no register" ID
STAT_W, 3, status width (AOK=1, HLT=2, ADR=3, INS=4)
CNT_W, 32, performance-counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
D_icode  in  ICODE_W  icode in the decode register
d_srcA  in  REG_W  decode-stage source A
d_srcB  in  REG_W  decode-stage source B
E_icode  in  ICODE_W  icode in the execute register
E_dstM  in  REG_W  execute-stage memory destination
e_cnd  in  1  execute-stage branch condition
M_icode  in  ICODE_W  icode in the memory register
m_stat  in  STAT_W  memory-stage status
W_icode  in  ICODE_W  icode in the writeback register
W_stat  in  STAT_W  writeback-stage status
F_stall  out  1  hold the PC register
D_stall  out  1  hold the decode register
D_bubble  out  1  load a nop into the decode register
E_bubble  out  1  load a nop into the execute register
M_bubble  out  1  load a nop into the memory register
W_stall  out  1  hold the writeback register
set_cc_en  out  1  allow a CC write in execute
state  out  2  0=RUN, 1=DRAIN, 2=HALTED
halt_stat  out  STAT_W  sticky final status
cycle_cnt  out  CNT_W  cycles in RUN or DRAIN
retire_cnt  out  CNT_W  retired non-nop instructions
stall_cnt  out  CNT_W  cycles with F_stall=1 in RUN
mispred_cnt  out  CNT_W  mispredicted jumps

Behaviour:
Encodings:
- icodes: HALT=0, NOP=1, JXX=7, RET=9, MRMOVQ=5, POPQ=B, OPQ=6.
- Status: AOK=1.

Definitions:
- loaduse = E_icode in {MRMOVQ, POPQ} and E_dstM != RNONE and E_dstM in {d_srcA, d_srcB}.
- mispred = E_icode==JXX and !e_cnd.
- retq = RET present in D, E or M.
- mexc = m_stat != AOK.
- wexc = W_stat != AOK.

Outputs are combinational from the inputs and the registered state. There is no latency on the control outputs.

In RUN:
- F_stall = loaduse | retq.
- D_stall = loaduse.
- D_bubble = mispred | (retq & !loaduse).
- E_bubble = mispred | loaduse.
- M_bubble = mexc | wexc.
- W_stall = wexc.
- set_cc_en = E_icode==OPQ & !mexc & !wexc.

Simultaneous-event rules:
- loaduse with retq: F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
- mispred with retq: D_bubble=1, E_bubble=1.
- D_stall and D_bubble are never both 1.

In DRAIN:
- Same equations as RUN, except set_cc_en=0 and M_bubble=1.

In HALTED:
- F_stall=1, D_stall=1, W_stall=1, M_bubble=1.
- D_bubble=0, E_bubble=0, set_cc_en=0.

Transitions (registered):
- RUN -> HALTED when wexc (takes priority); on the same edge, halt_stat <= W_stat.
- RUN -> DRAIN when mexc and !wexc.
- DRAIN -> HALTED when wexc; halt_stat <= W_stat.
- HALTED is held until rst.

Reset:
- rst=1 at a clock edge sets state=RUN, halt_stat=AOK and all counters to 0.
- Reset overrides any transition, including mid-DRAIN.
- Outputs reflect RUN from the following cycle.

Counters (saturate at all-ones, never wrap):
- cycle_cnt increments every cycle with state != HALTED.
- retire_cnt increments when W_icode != NOP, W_stat==AOK and state != HALTED.
- stall_cnt increments when F_stall=1 in RUN.
- mispred_cnt increments when mispred=1 in RUN or DRAIN.

Optional Feature:
PIPE_PERF_CNT_EN:
- Defined: the four counters and their increment logic are built as described.
- Undefined: cycle_cnt, retire_cnt, stall_cnt and mispred_cnt are constant 0 and no counter flops exist.
- Hazard, state and halt_stat behaviour is identical either way.

Test Plan:
1. rst=1 for 2 cycles, then release with all icodes=NOP and stats=AOK -> state=0, halt_stat=1, all control outputs 0, cycle_cnt increments by 1 per cycle.
2. E_icode=MRMOVQ, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. The same case with E_dstM=F -> all four outputs 0.
3. E_icode=JXX, e_cnd=0 -> D_bubble=1, E_bubble=1, mispred_cnt +1. With e_cnd=1 -> both outputs 0.
4. RET in D for one cycle, then in E, then in M -> F_stall=1 and D_bubble=1 on each of the 3 cycles. Adding loaduse in the first of those cycles -> D_bubble=0, D_stall=1.
5. m_stat=ADR for 1 cycle -> M_bubble=1 and state=DRAIN next cycle. Then W_stat=3 -> W_stall=1, state=HALTED next cycle, halt_stat=3, cycle_cnt frozen.
6. In HALTED, assert rst -> state=RUN and counters 0 after the edge. With the macro undefined -> counters read 0 throughout scenarios 1-5.
